wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter that owns the register file's single write port (we3, wa3, wd3). It merges two result sources into one registered write per cycle: the ALU path, which has fixed priority and no backpressure, and the memory-load path, which uses a valid/ready handshake and is buffered in a small FIFO. It drops writes to X31 and exports a pending-write scoreboard that the hazard/stall logic upstream uses.

## Interface
- N, 64: data width of results and of wd3
- DEPTH, 2: load-path FIFO depth in entries; legal values are 2..8
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- alu_valid  in  1  ALU result present this cycle
- alu_wa  in  5  ALU destination register
- alu_wd  in  N  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result is accepted this cycle when mem_valid=1
- mem_wa  in  5  load destination register
- mem_wd  in  N  load data
- we3  out  1  registered write enable to the register file
- wa3  out  5  registered write address
- wd3  out  N  registered write data
- pending  out  32  bit i is set when a write to Xi is held in the FIFO or in the output register with we3=1
- fifo_count  out  $clog2(DEPTH+1)  number of occupied FIFO entries
- order_err  out  1  registered one-cycle pulse flagging an ordering violation

## Operation
- Load accept:
  - A handshake occurs when mem_valid & mem_ready.
  - If mem_wa != 31, the entry {mem_wa, mem_wd} is pushed to the FIFO tail.
  - If mem_wa == 31, the handshake completes and the beat is discarded. No push occurs and fifo_count is unchanged.
- mem_ready = !reset & (fifo_count < DEPTH). It depends only on registered state, never on the same-cycle pop.
- ALU request: alu_req = alu_valid & (alu_wa != 31). An ALU result to X31 is treated as no request.
- Output selection, evaluated every cycle:
  - If alu_req, the output register loads {1, alu_wa, alu_wd}.
  - Else, if the FIFO is non-empty, the FIFO head is popped and the output register loads {1, head_wa, head_wd}.
  - Else, we3 loads 0. wa3 and wd3 hold their previous values.
- The FIFO is strict in-order. A push and a pop may occur in the same cycle.
  - fifo_count goes +1 for push only, -1 for pop only, and is unchanged for both or neither.
- A beat accepted at edge k is never popped at edge k. The earliest pop is at edge k+1, so there is no bypass.
- pending is the OR of one-hot(wa) over all valid FIFO entries, plus one-hot(wa3) when we3=1. It is combinational from registered state. Bit 31 is always 0.
- Ordering rule: the environment stalls the ALU on a WAW hazard against the FIFO.
  - If alu_req and pending[alu_wa] is set by a FIFO entry, the ALU write is still taken.
  - order_err pulses high on the next cycle.
- Reset mid-operation flushes all FIFO contents. No write is emitted for flushed entries.

## Timing
- Reset values: we3=0, wa3=0, wd3=0, fifo_count=0, pending=0, order_err=0, mem_ready=0 while reset is high. mem_ready is 1 in the first cycle after reset deasserts.
- ALU latency:
  - alu_req sampled at edge k drives we3/wa3/wd3 after edge k.
  - The register file commits the write at edge k+1.
- Load latency:
  - Minimum: accept at edge k, pop at edge k+1, register-file commit at edge k+2.
  - Each cycle with alu_req adds one cycle of delay for the head entry.
- Full: with fifo_count=DEPTH, mem_ready=0 for that whole cycle, even if a pop occurs at the same edge.
- Throughput: at most one register-file write per cycle. A full FIFO with no ALU traffic drains at one entry per cycle.
- we3 is high for exactly one cycle per emitted write. Back-to-back writes keep we3 high on consecutive cycles.

## Test plan
- Reset with alu_valid=1, alu_wa=5 held high → we3=0, pending=0, mem_ready=0. After release, the first edge gives we3=1, wa3=5.
- ALU only: alu_wa=14, alu_wd=64'hFFFF_AAAA_FFFF_CCCC → next cycle we3=1, wa3=14, wd3 matches. A regfile read of X14 returns that value one cycle later.
- Load path: mem beats X3=64'h11 and X4=64'h22 on consecutive cycles with no ALU → writes X3 then X4 at edges k+1 and k+2, fifo_count goes 1,1,0, and pending[3] and pending[4] each clear after their write.
- Contention and backpressure:
  - Stimulus: DEPTH=2, continuous alu_req to X7 while three load beats are offered.
  - mem_ready drops to 0 after two accepts.
  - No load write is emitted until alu_valid=0.
  - The loads then drain in order.
- X31 filtering: alu_wa=31 with a non-empty FIFO → the FIFO head pops that cycle. A mem beat with mem_wa=31 completes its handshake, fifo_count is unchanged, and no we3 pulse occurs.
- Ordering violation and flush:
  - alu_req to X9 while X9 is queued in the FIFO → order_err=1 for exactly one cycle.
  - Then assert reset with 2 entries queued → fifo_count=0, we3=0, and no further writes occur.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter owning the register file's single write port.
// ALU results win; load results queue in an in-order FIFO with valid/ready.
module wb_arbiter #(
    parameter int N     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_wa,
    input  logic [N-1:0]               alu_wd,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_wa,
    input  logic [N-1:0]               mem_wd,
    output logic                       we3,
    output logic [4:0]                 wa3,
    output logic [N-1:0]               wd3,
    output logic [31:0]                pending,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       order_err
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH-1);
    localparam logic [4:0]    X31  = 5'd31;

    logic [4:0]       r_fwa [DEPTH];
    logic [N-1:0]     r_fwd [DEPTH];
    logic [DEPTH-1:0] r_fvld;
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_cnt;

    logic             r_we;
    logic [4:0]       r_wa;
    logic [N-1:0]     r_wd;
    logic             r_oerr;

    logic             w_alu_req;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_fifo_pend;
    logic [31:0]      w_out_pend;
    logic [DEPTH-1:0] w_fvld_nxt;
    logic [CW-1:0]    w_cnt_nxt;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Ready only looks at registered occupancy, never at this cycle's pop.
    assign mem_ready = !reset && (r_cnt < FULL);
    assign w_alu_req = alu_valid && (alu_wa != X31);
    assign w_push    = mem_valid && mem_ready && (mem_wa != X31);
    assign w_pop     = !w_alu_req && (r_cnt != '0);

    always_comb begin
        w_fifo_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_fvld[i]) begin
                w_fifo_pend[r_fwa[i]] = 1'b1;
            end
        end
    end

    assign w_out_pend = r_we ? (32'd1 << r_wa) : 32'd0;
    assign pending    = (w_fifo_pend | w_out_pend) & 32'h7FFF_FFFF;

    always_comb begin
        w_fvld_nxt = r_fvld;
        if (w_pop) begin
            w_fvld_nxt[r_rd] = 1'b0;
        end
        if (w_push) begin
            w_fvld_nxt[r_wr] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        unique case (1'b1)
            (w_push && !w_pop): w_cnt_nxt = r_cnt + 1'b1;
            (w_pop && !w_push): w_cnt_nxt = r_cnt - 1'b1;
            default:            w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fwa[r_wr] <= mem_wa;
            r_fwd[r_wr] <= mem_wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
            r_fvld <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_fvld <= w_fvld_nxt;
            if (w_push) begin
                r_wr <= inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= inc(r_rd);
            end
        end
    end

    // A FIFO hit on the ALU target means upstream failed to stall on WAW.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_wa   <= '0;
            r_wd   <= '0;
            r_oerr <= 1'b0;
        end else begin
            r_we   <= w_alu_req || w_pop;
            r_oerr <= w_alu_req && w_fifo_pend[alu_wa];
            if (w_alu_req) begin
                r_wa <= alu_wa;
                r_wd <= alu_wd;
            end else if (w_pop) begin
                r_wa <= r_fwa[r_rd];
                r_wd <= r_fwd[r_rd];
            end
        end
    end

    assign we3        = r_we;
    assign wa3        = r_wa;
    assign wd3        = r_wd;
    assign fifo_count = r_cnt;
    assign order_err  = r_oerr;

endmodule
